// File: rtl/gtech_scan_unload_pkg.sv
// rtl/gtech_scan_unload_pkg.sv - shared types, constants and helpers for the scan-unload block
package gtech_scan_unload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Idle and vacated shift-register positions read as set-type flops.
    localparam logic FILL_BIT = 1'b1;

    // Bit count must reach WIDTH (parity slot) without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/gtech_unload_shreg.sv
// rtl/gtech_unload_shreg.sv - preset-to-ones shift register with parallel load and selectable output end
module gtech_unload_shreg
    import gtech_scan_unload_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             preset,
    input  logic [WIDTH-1:0] d,
    output logic             so
);

    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] sreg_shifted;

    // A single-bit register has nothing to move in; it simply refills.
    if (WIDTH == 1) begin : g_w1
        assign sreg_shifted = {WIDTH{FILL_BIT}};
    end else if (MSB_FIRST != 0) begin : g_msb
        assign sreg_shifted = {sreg_q[WIDTH-2:0], FILL_BIT};
    end else begin : g_lsb
        assign sreg_shifted = {FILL_BIT, sreg_q[WIDTH-1:1]};
    end

    // Next-value select: preset beats load beats shift.
    always_comb begin
        sreg_d = sreg_q;
        if (preset) begin
            sreg_d = {WIDTH{FILL_BIT}};
        end else if (load) begin
            sreg_d = d;
        end else if (shift) begin
            sreg_d = sreg_shifted;
        end
    end

    // Storage register, asynchronously preset to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= {WIDTH{FILL_BIT}};
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign so = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/gtech_scan_unload.sv
// rtl/gtech_scan_unload.sv - capture-and-serialise unload of a flop bank; GTECH_SCAN_UNLOAD_PARITY_EN appends even parity
module gtech_scan_unload
    import gtech_scan_unload_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             CP,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             CAP,
    input  logic             ABORT,
    output logic             SO,
    output logic             SO_VALID,
    input  logic             SO_READY,
    output logic             SO_LAST,
    output logic             BUSY,
    output logic             DONE_P,
    output logic             CAP_ERR
);

    localparam int CW = cnt_width(WIDTH);
`ifdef GTECH_SCAN_UNLOAD_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cap_err_q, cap_err_d;
    logic            sh_load, sh_shift, sh_preset, sh_so;
    logic            in_shift, xfer, last_bit;

    assign in_shift = (state_q == ST_SHIFT);
    assign xfer     = in_shift && SO_READY;
    assign last_bit = in_shift && (count_q == LAST_IDX);

    gtech_unload_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk    (CP),
        .rst    (RST),
        .load   (sh_load),
        .shift  (sh_shift),
        .preset (sh_preset),
        .d      (D),
        .so     (sh_so)
    );

    // FSM next state, bit counter and shift-register controls.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_preset = 1'b0;
        cap_err_d = CAP && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (CAP) begin
                    sh_load = 1'b1;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Cancel wins over a transfer on the same edge.
                if (ABORT) begin
                    sh_preset = 1'b1;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end else if (xfer) begin
                    sh_shift = 1'b1;
                    count_d  = count_q + CW'(1);
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                sh_preset = 1'b1;
                count_d   = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, counter and error-pulse registers.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            cap_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cap_err_q <= cap_err_d;
        end
    end

`ifdef GTECH_SCAN_UNLOAD_PARITY_EN
    logic parity_q, parity_d;

    // Even parity of the captured word, latched alongside the data.
    always_comb begin
        parity_d = parity_q;
        if ((state_q == ST_IDLE) && CAP) begin
            parity_d = ^D;
        end
    end

    // Parity storage.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            parity_q <= FILL_BIT;
        end else begin
            parity_q <= parity_d;
        end
    end

    // The data bits are exhausted once the count reaches WIDTH.
    assign SO = (in_shift && (count_q == CW'(WIDTH))) ? parity_q : sh_so;
`else
    assign SO = sh_so;
`endif

    assign SO_VALID = in_shift;
    assign SO_LAST  = last_bit;
    assign BUSY     = (state_q != ST_IDLE);
    assign DONE_P   = (state_q == ST_DONE);
    assign CAP_ERR  = cap_err_q;

endmodule

// File: tb/tb_gtech_scan_unload.sv
// tb/tb_gtech_scan_unload.sv - scoreboard bench for gtech_scan_unload (WIDTH=8 and WIDTH=1 instances)
module tb_gtech_scan_unload;

    localparam int W = 8;
`ifdef GTECH_SCAN_UNLOAD_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    typedef struct packed {
        logic so;
        logic last;
    } exp_t;

    logic       CP = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] D = 8'h00;
    logic       CAP = 1'b0, ABORT = 1'b0, SO_READY = 1'b0;
    logic       SO, SO_VALID, SO_LAST, BUSY, DONE_P, CAP_ERR;

    logic [0:0] d1 = 1'b0;
    logic       cap1 = 1'b0, abort1 = 1'b0, rdy1 = 1'b0;
    logic       so1, so_valid1, so_last1, busy1, done_p1, cap_err1;

    exp_t q[$];
    exp_t q1[$];
    int   total = 0, bad = 0;
    int   done_cnt = 0, cap_err_cnt = 0;
    logic hold_v = 1'b0, hold_so = 1'b0, hold_last = 1'b0;

    gtech_scan_unload #(.WIDTH(W), .MSB_FIRST(0)) u_dut (
        .CP(CP), .RST(RST), .D(D), .CAP(CAP), .ABORT(ABORT),
        .SO(SO), .SO_VALID(SO_VALID), .SO_READY(SO_READY), .SO_LAST(SO_LAST),
        .BUSY(BUSY), .DONE_P(DONE_P), .CAP_ERR(CAP_ERR)
    );

    gtech_scan_unload #(.WIDTH(1), .MSB_FIRST(0)) u_w1 (
        .CP(CP), .RST(RST), .D(d1), .CAP(cap1), .ABORT(abort1),
        .SO(so1), .SO_VALID(so_valid1), .SO_READY(rdy1), .SO_LAST(so_last1),
        .BUSY(busy1), .DONE_P(done_p1), .CAP_ERR(cap_err1)
    );

    always #5 CP = ~CP;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor for the WIDTH=8 instance: pops on each handshake, checks stall stability.
    always @(negedge CP) begin
        exp_t e;
        if (DONE_P) done_cnt++;
        if (CAP_ERR) cap_err_cnt++;
        if (hold_v && SO_VALID) begin
            chk("stall_so", SO, hold_so);
            chk("stall_last", SO_LAST, hold_last);
        end
        hold_v    = SO_VALID && !SO_READY && !ABORT && !RST;
        hold_so   = SO;
        hold_last = SO_LAST;
        if (SO_VALID && SO_READY && !ABORT && !RST) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer actual=%0b required=no_transfer", SO);
            end else begin
                e = q.pop_front();
                chk("so_bit", SO, e.so);
                chk("so_last", SO_LAST, e.last);
            end
        end
    end

    // Monitor for the WIDTH=1 instance.
    always @(negedge CP) begin
        exp_t e;
        if (so_valid1 && rdy1 && !RST) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w1_unexpected_xfer actual=%0b required=no_transfer", so1);
            end else begin
                e = q1.pop_front();
                chk("w1_so_bit", so1, e.so);
                chk("w1_so_last", so_last1, e.last);
            end
        end
    end

    task automatic tick;
        @(posedge CP);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input int nbits);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            e.so   = (i < W) ? d[i] : ^d;
            e.last = (i == FRAME - 1);
            q.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input bit toggle, input int cap_at,
                             input int abort_at, output int cycles);
        int n;
        bit fin;
        push_frame(d, (abort_at >= 0) ? abort_at : FRAME);
        D = d;
        CAP = 1'b1;
        tick();
        CAP = 1'b0;
        n = 0;
        fin = 1'b0;
        while (!fin && n < 200) begin
            SO_READY = toggle ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            CAP      = (n == cap_at);
            if (n == cap_at) D = 8'h5A;
            ABORT    = (n == abort_at);
            tick();
            CAP   = 1'b0;
            ABORT = 1'b0;
            n++;
            if (DONE_P || (n - 1) == abort_at) fin = 1'b1;
        end
        cycles = n;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL frame_timeout actual=%0d required=done", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, d0, ce, n;
        exp_t e;

        repeat (3) tick();
        chk("rst_so", SO, 1'b1);
        chk("rst_valid", SO_VALID, 1'b0);
        chk("rst_last", SO_LAST, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE_P, 1'b0);
        chk("rst_cap_err", CAP_ERR, 1'b0);
        RST = 1'b0;
        tick();

        // Reset mid-frame after three transfers.
        SO_READY = 1'b1;
        push_frame(8'hA5, 3);
        D = 8'hA5;
        CAP = 1'b1;
        tick();
        CAP = 1'b0;
        repeat (3) tick();
        d0 = done_cnt;
        RST = 1'b1;
        #1;
        chk("midrst_so", SO, 1'b1);
        chk("midrst_valid", SO_VALID, 1'b0);
        chk("midrst_busy", BUSY, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        chk("midrst_queue", q.size(), 0);
        chk("midrst_no_done", done_cnt, d0);

        // A5 with ready held high, then CAP in the DONE cycle.
        run_frame(8'hA5, 1'b0, -1, -1, cyc);
        chk("a5_cycles", cyc, FRAME);
        chk("a5_done_p", DONE_P, 1'b1);
        chk("a5_done_valid", SO_VALID, 1'b0);
        chk("a5_done_busy", BUSY, 1'b1);
        chk("a5_done_so", SO, 1'b1);
        D = 8'hFF;
        CAP = 1'b1;
        tick();
        CAP = 1'b0;
        chk("capdone_busy", BUSY, 1'b0);
        chk("capdone_err", CAP_ERR, 1'b1);
        chk("capdone_done_p", DONE_P, 1'b0);
        tick();
        chk("capdone_err_pulse", CAP_ERR, 1'b0);
        chk("capdone_valid", SO_VALID, 1'b0);

        // Same frame with ready toggling 1,0,0,1.
        run_frame(8'hA5, 1'b1, -1, -1, cyc);
        chk("stall_cycles", cyc, (PAR != 0) ? 17 : 16);
        tick();

        // CAP while shifting bit 4.
        ce = cap_err_cnt;
        run_frame(8'hA5, 1'b0, 4, -1, cyc);
        chk("capbusy_cycles", cyc, FRAME);
        tick();
        chk("capbusy_err_cnt", cap_err_cnt - ce, 1);

        // ABORT at bit 5, then a fresh 3C frame.
        d0 = done_cnt;
        run_frame(8'hA5, 1'b0, -1, 5, cyc);
        chk("abort_cycles", cyc, 6);
        chk("abort_valid", SO_VALID, 1'b0);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_so", SO, 1'b1);
        tick();
        tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_queue", q.size(), 0);
        run_frame(8'h3C, 1'b0, -1, -1, cyc);
        chk("c3_cycles", cyc, FRAME);
        tick();

        // 07 frame (odd population: parity bit 1 when enabled).
        run_frame(8'h07, 1'b0, -1, -1, cyc);
        chk("x07_cycles", cyc, FRAME);
        tick();

        // ABORT in IDLE has no effect.
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_idle_busy", BUSY, 1'b0);
        chk("abort_idle_so", SO, 1'b1);

        // WIDTH=1 instance: D=1 then D=0.
        for (int k = 0; k < 2; k++) begin
            e.so   = (k == 0);
            e.last = (PAR == 0);
            q1.push_back(e);
            if (PAR != 0) begin
                e.so   = (k == 0);
                e.last = 1'b1;
                q1.push_back(e);
            end
            rdy1 = 1'b1;
            d1   = (k == 0) ? 1'b1 : 1'b0;
            cap1 = 1'b1;
            tick();
            cap1 = 1'b0;
            n = 0;
            while (!done_p1 && n < 50) begin
                tick();
                n++;
            end
            chk("w1_cycles", n, 1 + PAR);
            tick();
            chk("w1_so_idle", so1, 1'b1);
        end

        tick();
        chk("final_queue", q.size(), 0);
        chk("final_queue_w1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
